// File: rtl/sad_compare_tree_pkg.sv
// Shared motion-estimation types and constants for the minimum-SAD selector.
// Provides candidate width, motion-vector width, candidate count and the
// (sad, idx) pair carried through every compare node.
package me_pkg;

  localparam int SAD_W  = 14;
  localparam int MV_W   = 4;
  localparam int N_CAND = 16;

  typedef struct packed {
    logic [SAD_W-1:0] sad;
    logic [MV_W-1:0]  idx;
  } sad_pair_t;

endpackage : me_pkg

// File: rtl/sad_compare_tree_if.sv
// Candidate/result bundle between the SAD accumulator array and the
// motion-vector output stage.
// Ports: in_valid, sad_0..sad_15 (to the selector); sad_cmp, motion_vec_y,
// out_valid (from the selector). No back-pressure path exists.
interface sad_compare_tree_if #(
  parameter int SAD_W = me_pkg::SAD_W
);
  logic             in_valid;
  logic [SAD_W-1:0] sad_0,  sad_1,  sad_2,  sad_3;
  logic [SAD_W-1:0] sad_4,  sad_5,  sad_6,  sad_7;
  logic [SAD_W-1:0] sad_8,  sad_9,  sad_10, sad_11;
  logic [SAD_W-1:0] sad_12, sad_13, sad_14, sad_15;
  logic [SAD_W-1:0] sad_cmp;
  logic [3:0]       motion_vec_y;
  logic             out_valid;

  // Upstream side: drives candidates, observes the result.
  modport master (
    output in_valid,
    output sad_0, sad_1, sad_2, sad_3, sad_4, sad_5, sad_6, sad_7,
    output sad_8, sad_9, sad_10, sad_11, sad_12, sad_13, sad_14, sad_15,
    input  sad_cmp, motion_vec_y, out_valid
  );

  // Selector side.
  modport slave (
    input  in_valid,
    input  sad_0, sad_1, sad_2, sad_3, sad_4, sad_5, sad_6, sad_7,
    input  sad_8, sad_9, sad_10, sad_11, sad_12, sad_13, sad_14, sad_15,
    output sad_cmp, motion_vec_y, out_valid
  );
endinterface : sad_compare_tree_if

// File: rtl/sad_compare_tree_min_pair.sv
// Combinational two-input compare node: passes the pair with the smaller SAD.
// Ports: a_i (left/lower-index pair), b_i (right pair), win_o (winner).
// Latency 0; no flow control. Equal values keep the left pair.
module min_pair #(
  parameter type pair_t = me_pkg::sad_pair_t
) (
  input  pair_t a_i,
  input  pair_t b_i,
  output pair_t win_o
);
  // Strict less-than keeps the lower index on ties, which makes the tree
  // return the lowest index among all equal minima.
  assign win_o = (b_i.sad < a_i.sad) ? b_i : a_i;
endmodule : min_pair

// File: rtl/sad_compare_tree.sv
// Minimum-SAD selector: 16 candidates -> smallest SAD and its 4-bit index.
// Ports: clk, rst (sync, active-high), bus (slave side of sad_compare_tree_if).
// Latency 1 cycle (2 with COMPARE_TREE_PIPE_EN); one result per cycle, no stall.
module sad_compare_tree #(
  parameter int SAD_W = me_pkg::SAD_W
) (
  input  logic               clk,
  input  logic               rst,
  sad_compare_tree_if.slave  bus
);
  import me_pkg::*;

  typedef struct packed {
    logic [SAD_W-1:0] sad;
    logic [MV_W-1:0]  idx;
  } pair_t;

  pair_t lvl0 [N_CAND];
  pair_t lvl1 [8];
  pair_t lvl2 [4];
  pair_t lvl2_s [4];
  pair_t lvl3 [2];
  pair_t lvl4;
  logic  vld_s;

  // Leaves carry their full index; each compare level then effectively
  // contributes one more MSB of the winning index.
  assign lvl0[0]  = '{sad: bus.sad_0,  idx: MV_W'(0)};
  assign lvl0[1]  = '{sad: bus.sad_1,  idx: MV_W'(1)};
  assign lvl0[2]  = '{sad: bus.sad_2,  idx: MV_W'(2)};
  assign lvl0[3]  = '{sad: bus.sad_3,  idx: MV_W'(3)};
  assign lvl0[4]  = '{sad: bus.sad_4,  idx: MV_W'(4)};
  assign lvl0[5]  = '{sad: bus.sad_5,  idx: MV_W'(5)};
  assign lvl0[6]  = '{sad: bus.sad_6,  idx: MV_W'(6)};
  assign lvl0[7]  = '{sad: bus.sad_7,  idx: MV_W'(7)};
  assign lvl0[8]  = '{sad: bus.sad_8,  idx: MV_W'(8)};
  assign lvl0[9]  = '{sad: bus.sad_9,  idx: MV_W'(9)};
  assign lvl0[10] = '{sad: bus.sad_10, idx: MV_W'(10)};
  assign lvl0[11] = '{sad: bus.sad_11, idx: MV_W'(11)};
  assign lvl0[12] = '{sad: bus.sad_12, idx: MV_W'(12)};
  assign lvl0[13] = '{sad: bus.sad_13, idx: MV_W'(13)};
  assign lvl0[14] = '{sad: bus.sad_14, idx: MV_W'(14)};
  assign lvl0[15] = '{sad: bus.sad_15, idx: MV_W'(15)};

  for (genvar j = 0; j < 8; j++) begin : g_l1
    min_pair #(.pair_t(pair_t)) u_node (
      .a_i(lvl0[2*j]), .b_i(lvl0[2*j+1]), .win_o(lvl1[j]));
  end

  for (genvar j = 0; j < 4; j++) begin : g_l2
    min_pair #(.pair_t(pair_t)) u_node (
      .a_i(lvl1[2*j]), .b_i(lvl1[2*j+1]), .win_o(lvl2[j]));
  end

`ifdef COMPARE_TREE_PIPE_EN
  // Mid-tree cut: the four level-2 survivors and their valid are registered.
  pair_t pipe_q [4];
  logic  pipe_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < 4; j++) pipe_q[j] <= '0;
      pipe_vld_q <= 1'b0;
    end else begin
      for (int j = 0; j < 4; j++) pipe_q[j] <= lvl2[j];
      pipe_vld_q <= bus.in_valid;
    end
  end

  for (genvar j = 0; j < 4; j++) begin : g_l2_sel
    assign lvl2_s[j] = pipe_q[j];
  end
  assign vld_s = pipe_vld_q;
`else
  for (genvar j = 0; j < 4; j++) begin : g_l2_sel
    assign lvl2_s[j] = lvl2[j];
  end
  assign vld_s = bus.in_valid;
`endif

  for (genvar j = 0; j < 2; j++) begin : g_l3
    min_pair #(.pair_t(pair_t)) u_node (
      .a_i(lvl2_s[2*j]), .b_i(lvl2_s[2*j+1]), .win_o(lvl3[j]));
  end

  min_pair #(.pair_t(pair_t)) u_root (
    .a_i(lvl3[0]), .b_i(lvl3[1]), .win_o(lvl4));

  // Output registers; data is loaded unconditionally, valid qualifies it.
  logic [SAD_W-1:0] sad_cmp_q, sad_cmp_d;
  logic [MV_W-1:0]  mv_q, mv_d;
  logic             out_vld_q, out_vld_d;

  always_comb begin
    sad_cmp_d = lvl4.sad;
    mv_d      = lvl4.idx;
    out_vld_d = vld_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sad_cmp_q <= '0;
      mv_q      <= '0;
      out_vld_q <= 1'b0;
    end else begin
      sad_cmp_q <= sad_cmp_d;
      mv_q      <= mv_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign bus.sad_cmp      = sad_cmp_q;
  assign bus.motion_vec_y = mv_q;
  assign bus.out_valid    = out_vld_q;

endmodule : sad_compare_tree

// File: tb/tb_sad_compare_tree.sv
// Directed bench for sad_compare_tree: vector table streamed back-to-back,
// then reset-while-in-flight and recovery sequences.
// Honours COMPARE_TREE_PIPE_EN for the expected latency.
module tb_sad_compare_tree;

`ifdef COMPARE_TREE_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NV = 9;

  typedef struct packed {
    logic             vld;
    logic [15:0][13:0] sad;
    logic [13:0]      exp_sad;
    logic [3:0]       exp_mv;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl [NV];

  always #5 clk = ~clk;

  sad_compare_tree_if #(.SAD_W(14)) bus ();

  sad_compare_tree #(.SAD_W(14)) compare_tree (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid = v.vld;
    bus.sad_0  = v.sad[0];  bus.sad_1  = v.sad[1];
    bus.sad_2  = v.sad[2];  bus.sad_3  = v.sad[3];
    bus.sad_4  = v.sad[4];  bus.sad_5  = v.sad[5];
    bus.sad_6  = v.sad[6];  bus.sad_7  = v.sad[7];
    bus.sad_8  = v.sad[8];  bus.sad_9  = v.sad[9];
    bus.sad_10 = v.sad[10]; bus.sad_11 = v.sad[11];
    bus.sad_12 = v.sad[12]; bus.sad_13 = v.sad[13];
    bus.sad_14 = v.sad[14]; bus.sad_15 = v.sad[15];
  endtask

  function automatic vec_t mk_fill(input int val, input int es, input int em);
    vec_t v;
    v.vld = 1'b1;
    for (int k = 0; k < 16; k++) v.sad[k] = 14'(val);
    v.exp_sad = 14'(es);
    v.exp_mv  = 4'(em);
    return v;
  endfunction

  initial begin
    int s1 [16] = '{45, 7, 2, 3, 4, 6, 6, 7, 8, 9, 10, 11, 132, 13, 14, 15};
    int s2 [16] = '{435, 234, 345, 489, 3457, 23, 347, 3983,
                    2349, 912, 1342, 135, 1334, 134, 135, 1349};
    vec_t idle;

    // Vector table
    tbl[0] = mk_fill(0, 0, 0);
    for (int k = 0; k < 16; k++) tbl[0].sad[k] = 14'(k);          // ramp
    tbl[1] = mk_fill(0, 2, 2);
    for (int k = 0; k < 16; k++) tbl[1].sad[k] = 14'(s1[k]);
    tbl[2] = mk_fill(0, 23, 5);
    for (int k = 0; k < 16; k++) tbl[2].sad[k] = 14'(s2[k]);
    tbl[3] = mk_fill(16383, 16383, 0);                              // all equal max
    tbl[4] = mk_fill(100, 50, 9);
    tbl[4].sad[9] = 14'd50; tbl[4].sad[13] = 14'd50;               // tie in right half
    tbl[5] = mk_fill(500, 499, 15);
    tbl[5].sad[15] = 14'd499;                                       // last index
    tbl[6] = mk_fill(1, 0, 0);
    tbl[6].vld = 1'b0;                                              // bubble
    tbl[7] = mk_fill(7, 3, 8);
    tbl[7].sad[8] = 14'd3; tbl[7].sad[12] = 14'd3;                 // tie across halves
    tbl[8] = mk_fill(8192, 8191, 6);
    tbl[8].sad[6] = 14'd8191;                                       // MSB boundary

    idle = tbl[0];
    idle.vld = 1'b0;

    // Reset with valid garbage on the inputs: rst must win.
    rst = 1'b1;
    drive(tbl[1]);
    repeat (3) @(negedge clk);
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset sad_cmp", int'(bus.sad_cmp), 0);
    chk("reset motion_vec_y", int'(bus.motion_vec_y), 0);
    rst = 1'b0;
    drive(idle);

    // Stream the table back-to-back; result for vector e appears LAT cycles later.
    for (int c = 0; c < NV + LAT; c++) begin
      int e;
      @(negedge clk);
      e = c - LAT;
      if (e < 0) begin
        chk($sformatf("pre-stream out_valid c%0d", c), int'(bus.out_valid), 0);
      end else begin
        chk($sformatf("out_valid v%0d", e), int'(bus.out_valid), int'(tbl[e].vld));
        if (tbl[e].vld) begin
          chk($sformatf("sad_cmp v%0d", e), int'(bus.sad_cmp), int'(tbl[e].exp_sad));
          chk($sformatf("motion_vec_y v%0d", e), int'(bus.motion_vec_y), int'(tbl[e].exp_mv));
        end
      end
      if (c < NV) drive(tbl[c]);
      else        drive(idle);
    end

    @(negedge clk);
    chk("idle out_valid", int'(bus.out_valid), 0);

    // Reset while results are in flight.
    drive(tbl[1]);
    @(negedge clk);
    rst = 1'b1;
    drive(tbl[2]);
    @(negedge clk);
    chk("midrst out_valid", int'(bus.out_valid), 0);
    chk("midrst sad_cmp", int'(bus.sad_cmp), 0);
    chk("midrst motion_vec_y", int'(bus.motion_vec_y), 0);
    rst = 1'b0;
    drive(idle);
    for (int c = 0; c < LAT; c++) begin
      @(negedge clk);
      chk($sformatf("post-rst flushed c%0d", c), int'(bus.out_valid), 0);
    end

    // First valid input after reset emerges after exactly LAT cycles.
    drive(tbl[4]);
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      drive(idle);
      if (c < LAT) chk($sformatf("recover early c%0d", c), int'(bus.out_valid), 0);
    end
    chk("recover out_valid", int'(bus.out_valid), 1);
    chk("recover sad_cmp", int'(bus.sad_cmp), 50);
    chk("recover motion_vec_y", int'(bus.motion_vec_y), 9);
    @(negedge clk);
    chk("recover single pulse", int'(bus.out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sad_compare_tree

// File: doc/sad_compare_tree.md
# sad_compare_tree

Minimum-SAD selector for the motion-estimation core. Takes 16 sum-of-absolute-difference candidates, one per vertical search offset. Returns the smallest SAD and the 4-bit index of the candidate that produced it, which is the vertical motion vector. Sits between the SAD accumulator array and the motion-vector output stage; the module is instantiated as `compare_tree`.

## Interface
- `SAD_W`, default 14: width of each SAD candidate and of the result.
- `N`, fixed 16: number of candidates (not overridable; index width is 4).
- `clk` input, 1: single clock; all state updates on rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `in_valid` input, 1: the 16 SAD inputs are valid this cycle.
- `sad_0` … `sad_15` input, `SAD_W` each: unsigned SAD candidates; index k = port `sad_k`.
- `sad_cmp` output, `SAD_W`: minimum of the 16 candidates.
- `motion_vec_y` output, 4: index (0–15) of the minimum candidate.
- `out_valid` output, 1: `sad_cmp`/`motion_vec_y` hold a new result.

## Operation
- Balanced binary tree of 15 two-input compare nodes in 4 levels (8, 4, 2, 1).
- Each node carries a (value, index) pair and outputs the pair with the smaller value.
- Comparison is unsigned and width-exact: no saturation, no truncation.
- Tie rule: on equal values the lower-index (left) pair wins, i.e. right is chosen only if right < left strictly. Consequently the global result is the lowest index among all equal minima.
- Index bits are built up level by level: leaf pair (2j, 2j+1) yields a 1-bit select, and each level prepends one MSB.
- No handshake back-pressure: a new input set may be presented every cycle and is always accepted when `in_valid`=1.
- Inputs with `in_valid`=0 still propagate through the datapath. `out_valid` tracks `in_valid` delayed by the latency, and the data outputs are don't-care when `out_valid`=0.

## Timing
- Compare logic is combinational; outputs are registered.
- Default latency is 1 cycle: inputs sampled on edge n appear on `sad_cmp`/`motion_vec_y`/`out_valid` after edge n.
- Throughput is one result per cycle.
- Reset values: `sad_cmp`=0, `motion_vec_y`=0, `out_valid`=0, and any internal pipeline registers = 0 / invalid.
- Reset asserted mid-stream clears all in-flight results. The first valid output after deassertion corresponds to the first input with `in_valid`=1 sampled while `rst`=0.
- `rst` has priority over `in_valid` on the same edge.

## Configuration
- `COMPARE_TREE_PIPE_EN` defined: an extra register stage after tree level 2 (4 surviving pairs plus their valid bit); latency becomes 2 cycles; throughput unchanged. The added registers reset like the outputs.
- `COMPARE_TREE_PIPE_EN` undefined: no intermediate register; latency 1 cycle.

## Structure
- Shared package `me_pkg`: `SAD_W` (14), `MV_W` (4), `N_CAND` (16), and a typedef for the (sad, idx) pair struct.
- One sub-module, `min_pair`: combinational two-input compare node. It takes two (value, index) pairs and outputs the winner using the lower-index-on-tie rule. Instantiated 15 times via generate.

## Test plan
- Sequential ramp `sad_k`=k (0…15), `in_valid`=1 -> `sad_cmp`=0, `motion_vec_y`=0, `out_valid`=1 after latency.
- Set {45,7,2,3,4,6,6,7,8,9,10,11,132,13,14,15} -> `sad_cmp`=2, `motion_vec_y`=2.
- Set {435,234,345,489,3457,23,347,3983,2349,912,1342,135,1334,134,135,1349} -> `sad_cmp`=23, `motion_vec_y`=5. The three sets are applied on consecutive cycles and must emerge back-to-back.
- Ties: all inputs 16383 -> `sad_cmp`=16383, `motion_vec_y`=0. Inputs all 100 except `sad_9`=`sad_13`=50 -> `sad_cmp`=50, `motion_vec_y`=9.
- Last-index minimum: all 500 except `sad_15`=499 -> `sad_cmp`=499, `motion_vec_y`=15.
- Reset: assert `rst` while a result is in flight -> next edge `out_valid`=0, `sad_cmp`=0, `motion_vec_y`=0. Repeat the suite with `COMPARE_TREE_PIPE_EN` defined and check 2-cycle latency.
